// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmit path, receive path and benches.
//   uart_state_e    : transmitter FSM states (PARITY exists only with UART_TX_PARITY_EN)
//   calc_baud_div() : clocks per bit from clock frequency and line rate
//   FRAME_BITS*     : bits per frame for 8N1 / 8E1 and for the active build
// Optional feature macro: UART_TX_PARITY_EN (even parity bit between data and stop).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS     = FRAME_BITS_8E1;
`else
  localparam int FRAME_BITS     = FRAME_BITS_8N1;
`endif

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo -- single-clock FIFO with show-ahead read.
//   clk, rst_n      : clock, asynchronous active-low reset (pointers and count only)
//   wr_en, wr_data  : push; ignored while full
//   rd_en, rd_data  : pop; rd_data always shows the head entry
//   count           : entries stored
//   full, empty     : derived from count, so wrapped pointers are never ambiguous
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_acc, rd_acc;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    wr_acc   = wr_en & ~full;
    rd_acc   = rd_en & ~empty;
    // Depth is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- buffered UART transmitter, 8N1 LSB first (8E1 with UART_TX_PARITY_EN).
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_data     : byte to enqueue, sampled only on accepted writes
//   wr_en       : write strobe, accepted when full=0
//   full        : FIFO holds FIFO_DEPTH entries
//   overflow    : one-cycle pulse after a write attempted while full (byte dropped)
//   fifo_count  : bytes waiting (excludes the byte in the shifter)
//   tx_busy     : start, data, parity or stop bit being driven
//   rs232_tx    : serial line, idle high
// Optional feature macro: UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          rs232_tx
);

  import uart_pkg::*;

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [7:0]       fifo_rd_data;
  logic             fifo_empty, fifo_full, pop;

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign full     = fifo_full;
  assign overflow = overflow_q;
  assign tx_busy  = busy_q;
  assign rs232_tx = tx_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    overflow_d = wr_en & fifo_full;
    bit_end    = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));

    if (state_q == IDLE) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        shift_d    = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
        parity_d   = ^fifo_rd_data;
`endif
        tx_d       = 1'b0;
        busy_d     = 1'b1;
        baud_cnt_d = '0;
        state_d    = START;
      end
    end else begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          START: begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            tx_d      = shift_q[0];
          end
          DATA: begin
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = parity_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              // Shift right so the next bit to send is always shift_q[0].
              bit_idx_d = bit_idx_q + 3'd1;
              shift_d   = {1'b0, shift_q[7:1]};
              tx_d      = shift_q[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
`endif
          STOP: begin
            // Chain straight into the next frame when data is waiting.
            if (!fifo_empty) begin
              pop      = 1'b1;
              shift_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
              parity_d = ^fifo_rd_data;
`endif
              tx_d     = 1'b0;
              state_d  = START;
            end else begin
              tx_d     = 1'b1;
              busy_d   = 1'b0;
              state_d  = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- self-checking bench for uart_tx_fifo at BAUD_DIV = 10.
// Reference model: byte queue plus "frame start time" arithmetic for the line level.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 16;
  localparam int DIV      = calc_baud_div(CLK_FREQ, BAUD);
  localparam int FCLK     = FRAME_BITS * DIV;

  logic       clk, rst_n, wr_en, full, overflow, tx_busy, rs232_tx;
  logic [7:0] wr_data;
  logic [$clog2(DEPTH):0] fifo_count;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .full(full),
    .overflow(overflow), .fifo_count(fifo_count), .tx_busy(tx_busy), .rs232_tx(rs232_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model state
  logic [7:0] qm[$];      // bytes waiting
  logic [7:0] acc_q[$];   // every accepted byte, in order
  logic [7:0] dec_q[$];   // bytes decoded from the line
  bit         act = 1'b0; // frame in progress
  int         pos = 0;    // clocks since frame start
  logic [7:0] cur = 8'h00;
  bit         ov_m = 1'b0;

  // Line decoder state
  bit         dec_act = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;

  // Scenario statistics
  int max_cnt, ov_pulses, busy_cycles;
  bit full_seen;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] f8n1;   // line level per bit slot, slot 0 = bit 0
    logic [10:0] f8e1;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act_v, exp_v);
    end
  endtask

  task automatic model_reset();
    qm.delete(); acc_q.delete(); dec_q.delete();
    act = 1'b0; pos = 0; ov_m = 1'b0;
  endtask

  task automatic model_step();
    bit full_pre;
    full_pre = (qm.size() == DEPTH);
    ov_m = wr_en && full_pre;
    if (act) begin
      pos++;
      if (pos == FCLK) begin
        if (qm.size() != 0) begin cur = qm.pop_front(); pos = 0; end
        else act = 1'b0;
      end
    end else if (qm.size() != 0) begin
      cur = qm.pop_front(); act = 1'b1; pos = 0;
    end
    if (wr_en && !full_pre) begin
      qm.push_back(wr_data);
      acc_q.push_back(wr_data);
    end
  endtask

  function automatic logic exp_tx();
    int slot;
    if (!act) return 1'b1;
    slot = pos / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return cur[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^cur;
`endif
    return 1'b1;
  endfunction

  task automatic check_cycle();
    logic [31:0] a, e;
    a = 32'({rs232_tx, tx_busy, full, overflow, fifo_count});
    e = 32'({exp_tx(), act, (qm.size() == DEPTH), ov_m, 5'(qm.size())});
    check("cycle{tx,busy,full,ovf,count}", a, e);
  endtask

  task automatic decode_line();
    int slot;
    if (!rst_n) begin dec_act = 1'b0; return; end
    if (!dec_act) begin
      if (rs232_tx == 1'b0) begin dec_act = 1'b1; dec_cnt = 0; dec_byte = 8'h00; end
    end else begin
      dec_cnt++;
      if (dec_cnt % DIV == DIV / 2) begin
        slot = dec_cnt / DIV;
        if (slot == 0) check("start_bit", 32'(rs232_tx), 32'd0);
        else if (slot <= 8) dec_byte[slot-1] = rs232_tx;
        else if (slot == FRAME_BITS - 1) begin
          check("stop_bit", 32'(rs232_tx), 32'd1);
          dec_q.push_back(dec_byte);
          dec_act = 1'b0;
        end
`ifdef UART_TX_PARITY_EN
        else check("parity_bit", 32'(rs232_tx), 32'(^dec_byte));
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_cycle();
    decode_line();
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (overflow) ov_pulses++;
    if (tx_busy) busy_cycles++;
    if (full) full_seen = 1'b1;
  endtask

  task automatic clear_stats();
    max_cnt = 0; ov_pulses = 0; busy_cycles = 0; full_seen = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0; wr_data = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((act || qm.size() != 0 || tx_busy) && n < (DEPTH + 2) * FCLK + 10) begin
      tick(); n++;
    end
    if (act || qm.size() != 0 || tx_busy) check("drain_timeout_busy", 32'(tx_busy), 32'd0);
  endtask

  task automatic compare_decoded(input string name);
    check({name, "_len"}, 32'(dec_q.size()), 32'(acc_q.size()));
    for (int i = 0; i < acc_q.size() && i < dec_q.size(); i++)
      check({name, "_byte"}, 32'(dec_q[i]), 32'(acc_q[i]));
    acc_q.delete(); dec_q.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] exp_frame;
    int n;

    tbl[0] = '{8'h55, 11'b00_1010101010, 11'b100_1010_1010};
    tbl[1] = '{8'h07, 11'b00_1000001110, 11'b110_0000_1110};
    tbl[2] = '{8'h03, 11'b00_1000000110, 11'b100_0000_0110};
    tbl[3] = '{8'hA5, 11'b00_1101001010, 11'b101_0100_1010};
    tbl[4] = '{8'hFF, 11'b00_1111111110, 11'b101_1111_1110};

    // Reset state
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(rs232_tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single frames from the vector table
    for (int t = 0; t < 5; t++) begin
      drain();
`ifdef UART_TX_PARITY_EN
      exp_frame = tbl[t].f8e1;
`else
      exp_frame = tbl[t].f8n1;
`endif
      write_byte(tbl[t].data);
      for (int k = 0; k < FCLK; k++) begin
        tick();
        if (k == 0) check("tbl_latency", 32'(rs232_tx), 32'd0);
        if (k % DIV == DIV / 2) check("tbl_bit", 32'(rs232_tx), 32'(exp_frame[k / DIV]));
      end
      check("tbl_busy_hold", 32'(tx_busy), 32'd1);
      tick();
      check("tbl_busy_fall", 32'(tx_busy), 32'd0);
      compare_decoded("tbl_decode");
    end

    // Three back-to-back frames
    drain(); clear_stats();
    wr_en = 1'b1; wr_data = 8'hA5; tick();
    wr_data = 8'h3C; tick();
    wr_data = 8'hFF; tick();
    wr_en = 1'b0;
    drain();
    check("b2b_busy_cycles", 32'(busy_cycles), 32'(3 * FCLK));
    check("b2b_peak_count", 32'(max_cnt), 32'd2);
    compare_decoded("b2b_decode");

    // 18 consecutive writes: fill, overflow, drop
    drain(); clear_stats();
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_data = 8'(i * 13 + 1); tick();
    end
    wr_en = 1'b0;
    drain();
    check("ovf_pulses", 32'(ov_pulses), 32'd1);
    check("ovf_full_seen", 32'(full_seen), 32'd1);
    check("ovf_sent", 32'(dec_q.size()), 32'd17);
    compare_decoded("ovf_decode");

    // Reset during data bit 4 of 0x0F with three bytes queued
    drain();
    write_byte(8'h0F); write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    check("rstmid_pre_count", 32'(fifo_count), 32'd3);
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_tx", 32'(rs232_tx), 32'd1);
    check("rstmid_count", 32'(fifo_count), 32'd0);
    check("rstmid_busy", 32'(tx_busy), 32'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    write_byte(8'h00);
    drain();
    check("rstmid_sent", 32'(dec_q.size()), 32'd1);
    compare_decoded("rstmid_decode");

    // Count 15 with a pop on the same edge as a write
    drain();
    for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i));
    check("c15_count", 32'(fifo_count), 32'd15);
    n = 0;
    while (!(act && pos == FCLK - 1) && n < 2 * FCLK) begin tick(); n++; end
    check("c15_pre_count", 32'(fifo_count), 32'd15);
    wr_en = 1'b1; wr_data = 8'h99; tick(); wr_en = 1'b0;
    check("c15_same_edge_count", 32'(fifo_count), 32'd15);
    check("c15_same_edge_full", 32'(full), 32'd0);
    write_byte(8'h9A);
    check("c16_count", 32'(fifo_count), 32'd16);
    check("c16_full", 32'(full), 32'd1);
    drain();
    compare_decoded("c15_decode");

    // Randomised traffic: a heavy burst phase, then a sparse phase
    drain();
    for (int i = 0; i < 2500; i++) begin
      wr_en   = ($urandom_range(0, 99) < ((i < 1000) ? 30 : 2));
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    drain();
    compare_decoded("rand_decode");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
